shot_responder: RTL and testbench

SHOT_RESPONDER -- requirements
Module: shot_responder

---
 rtl/shot_responder_if.sv | 20 ++
 rtl/shot_responder.sv | 163 ++++++++++++++++
 tb/tb_shot_responder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shot_responder_if.sv
// Shot/reply handshake between an opponent and the responder.
// master drives shots and acks; slave answers with replies.
interface shot_responder_if;
    logic       shot_valid;
    logic [7:0] shot_addr;
    logic       shot_ready;
    logic       reply_valid;
    logic [1:0] reply_code;
    logic       reply_ack;

    modport master (
        output shot_valid, shot_addr, reply_ack,
        input  shot_ready, reply_valid, reply_code
    );

    modport slave (
        input  shot_valid, shot_addr, reply_ack,
        output shot_ready, reply_valid, reply_code
    );
endinterface

// File: rtl/shot_responder.sv
// Battleship board that answers opponent shots.
// 10x10 board of {ship, hit}; setup, arm, then shot/reply loop.
module shot_responder (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   place_we,
    input  logic [7:0]             place_addr,
    input  logic                   place_ship,
    input  logic                   arm,
    shot_responder_if.slave        bus,
    output logic [6:0]             ship_cells,
    output logic [6:0]             cells_left,
    output logic                   armed,
    output logic                   defeated
);

    typedef enum logic [2:0] {
        SETUP, READY, CHECK, REPLY, DONE
    } state_t;

    localparam logic [1:0] INVALID = 2'b00;
    localparam logic [1:0] MISS    = 2'b01;
    localparam logic [1:0] HIT     = 2'b10;
    localparam logic [1:0] SUNK    = 2'b11;

    state_t      state, state_d;
    logic [99:0] ship_q, ship_d;
    logic [99:0] hit_q, hit_d;
    logic [6:0]  sc_d, cl_d;
    logic [7:0]  addr_q, addr_d;
    logic        rv_q, rv_d;
    logic [1:0]  code_q, code_d;

    logic        place_ok, shot_ok;
    logic [6:0]  place_idx, shot_idx;

    function automatic logic cell_valid(input logic [7:0] a);
        return (a[7:4] <= 4'd9) && (a[3:0] <= 4'd9);
    endfunction

    function automatic logic [6:0] cell_idx(input logic [7:0] a);
        logic [6:0] r;
        logic [6:0] c;
        r = {3'b000, a[7:4]};
        c = {3'b000, a[3:0]};
        return r * 7'd10 + c;
    endfunction

    assign place_ok  = cell_valid(place_addr);
    assign place_idx = cell_idx(place_addr);
    assign shot_ok   = cell_valid(addr_q);
    assign shot_idx  = cell_idx(addr_q);

    // Next-state and next-datapath values; clear overrides everything.
    always_comb begin
        state_d = state;
        ship_d  = ship_q;
        hit_d   = hit_q;
        sc_d    = ship_cells;
        cl_d    = cells_left;
        addr_d  = addr_q;
        rv_d    = rv_q;
        code_d  = code_q;
        if (clear) begin
            state_d = SETUP;
            ship_d  = '0;
            hit_d   = '0;
            sc_d    = '0;
            cl_d    = '0;
            rv_d    = 1'b0;
            code_d  = INVALID;
        end else begin
            unique case (state)
                SETUP: begin
                    if (arm && ship_cells != 7'd0) begin
                        cl_d    = ship_cells;
                        state_d = READY;
                    end else if (place_we && place_ok) begin
                        if (place_ship && !ship_q[place_idx]) begin
                            ship_d[place_idx] = 1'b1;
                            sc_d = ship_cells + 7'd1;
                        end else if (!place_ship && ship_q[place_idx]) begin
                            ship_d[place_idx] = 1'b0;
                            sc_d = ship_cells - 7'd1;
                        end
                    end
                end
                READY: begin
                    if (bus.shot_valid) begin
                        addr_d  = bus.shot_addr;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    rv_d    = 1'b1;
                    state_d = REPLY;
                    if (!shot_ok) begin
                        code_d = INVALID;
                    end else if (!ship_q[shot_idx] || hit_q[shot_idx]) begin
                        code_d = MISS;
                    end else begin
                        hit_d[shot_idx] = 1'b1;
                        if (cells_left != 7'd0) begin
                            cl_d = cells_left - 7'd1;
                        end
                        code_d = (cells_left <= 7'd1) ? SUNK : HIT;
                    end
                end
                REPLY: begin
                    if (bus.reply_ack) begin
                        rv_d    = 1'b0;
                        state_d = (code_q == SUNK) ? DONE : READY;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = SETUP;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETUP;
        end else begin
            state <= state_d;
        end
    end

    // Board, counters, latched shot and registered reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ship_q     <= '0;
            hit_q      <= '0;
            ship_cells <= '0;
            cells_left <= '0;
            addr_q     <= '0;
            rv_q       <= 1'b0;
            code_q     <= INVALID;
        end else begin
            ship_q     <= ship_d;
            hit_q      <= hit_d;
            ship_cells <= sc_d;
            cells_left <= cl_d;
            addr_q     <= addr_d;
            rv_q       <= rv_d;
            code_q     <= code_d;
        end
    end

    assign bus.shot_ready  = (state == READY);
    assign bus.reply_valid = rv_q;
    assign bus.reply_code  = code_q;
    assign armed    = (state == READY) || (state == CHECK) ||
                      (state == REPLY);
    assign defeated = (state == DONE);

endmodule

// File: tb/tb_shot_responder.sv
// Bench for shot_responder: directed table, corner sequences,
// and random games checked against an array-based board model.
module tb_shot_responder;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       place_we;
    logic [7:0] place_addr;
    logic       place_ship;
    logic       arm;
    logic [6:0] ship_cells;
    logic [6:0] cells_left;
    logic       armed;
    logic       defeated;

    shot_responder_if bus ();

    shot_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .place_we   (place_we),
        .place_addr (place_addr),
        .place_ship (place_ship),
        .arm        (arm),
        .bus        (bus),
        .ship_cells (ship_cells),
        .cells_left (cells_left),
        .armed      (armed),
        .defeated   (defeated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference board: plain arrays, counts derived by summation.
    bit m_ship[100];
    bit m_hit[100];

    function automatic bit m_valid(input logic [7:0] a);
        return (a[7:4] < 10) && (a[3:0] < 10);
    endfunction

    function automatic int m_idx(input logic [7:0] a);
        return int'(a[7:4]) * 10 + int'(a[3:0]);
    endfunction

    function automatic int m_ship_count();
        int n = 0;
        for (int i = 0; i < 100; i++) n += m_ship[i];
        return n;
    endfunction

    function automatic int m_left();
        int n = 0;
        for (int i = 0; i < 100; i++) n += (m_ship[i] && !m_hit[i]);
        return n;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 100; i++) begin
            m_ship[i] = 1'b0;
            m_hit[i]  = 1'b0;
        end
    endfunction

    function automatic void m_place(input logic [7:0] a, input bit s);
        if (m_valid(a)) m_ship[m_idx(a)] = s;
    endfunction

    function automatic logic [1:0] m_shot(input logic [7:0] a);
        int i;
        if (!m_valid(a)) return 2'b00;
        i = m_idx(a);
        if (!m_ship[i] || m_hit[i]) return 2'b01;
        m_hit[i] = 1'b1;
        return (m_left() == 0) ? 2'b11 : 2'b10;
    endfunction

    task automatic place(input logic [7:0] a, input bit s);
        @(negedge clk);
        place_we   = 1'b1;
        place_addr = a;
        place_ship = s;
        @(negedge clk);
        place_we   = 1'b0;
    endtask

    task automatic do_arm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic accept(input string name, input logic [7:0] a,
                          output bit ok);
        int n = 0;
        while (!bus.shot_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " ready"}, bus.shot_ready, 1);
        ok = bus.shot_ready;
        if (!ok) return;
        bus.shot_valid = 1'b1;
        bus.shot_addr  = a;
        @(negedge clk);
        bus.shot_valid = 1'b0;
    endtask

    task automatic shoot(input string name, input logic [7:0] a,
                         input int hold, input logic [1:0] code,
                         input int left);
        bit ok;
        accept(name, a, ok);
        if (!ok) return;
        check({name, " rv_check"}, bus.reply_valid, 0);
        @(negedge clk);
        check({name, " rv"}, bus.reply_valid, 1);
        check({name, " code"}, bus.reply_code, code);
        check({name, " left"}, cells_left, left);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({name, " hold_rv"}, bus.reply_valid, 1);
            check({name, " hold_code"}, bus.reply_code, code);
        end
        bus.reply_ack = 1'b1;
        @(negedge clk);
        bus.reply_ack = 1'b0;
        check({name, " rv_ack"}, bus.reply_valid, 0);
    endtask

    typedef struct {
        logic [7:0] addr;
        int         hold;
        logic [1:0] code;
        int         left;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit         ok;
        bit         seen;
        logic [7:0] a;
        logic [3:0] r;
        logic [3:0] c;
        logic [7:0] ships[$];
        logic [1:0] ec;

        vecs[0] = '{8'h01, 5, 2'b10, 2};
        vecs[1] = '{8'h01, 0, 2'b01, 2};
        vecs[2] = '{8'h3A, 1, 2'b00, 2};
        vecs[3] = '{8'hA3, 0, 2'b00, 2};
        vecs[4] = '{8'h44, 2, 2'b01, 2};
        vecs[5] = '{8'h00, 0, 2'b10, 1};
        vecs[6] = '{8'h95, 3, 2'b11, 0};

        clear = 0; place_we = 0; place_addr = 0;
        place_ship = 0; arm = 0;
        bus.shot_valid = 0; bus.shot_addr = 0; bus.reply_ack = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check("rst shot_ready", bus.shot_ready, 0);
        check("rst reply_valid", bus.reply_valid, 0);
        check("rst reply_code", bus.reply_code, 0);
        check("rst ship_cells", ship_cells, 0);
        check("rst cells_left", cells_left, 0);
        check("rst armed", armed, 0);
        check("rst defeated", defeated, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed game.
        m_clear();
        place(8'h00, 1);
        place(8'h01, 1);
        place(8'h95, 1);
        do_arm();
        check("arm ship_cells", ship_cells, 3);
        check("arm cells_left", cells_left, 3);
        check("arm shot_ready", bus.shot_ready, 1);
        check("arm armed", armed, 1);
        for (int i = 0; i < 7; i++) begin
            shoot($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hold,
                  vecs[i].code, vecs[i].left);
        end
        check("done defeated", defeated, 1);
        check("done shot_ready", bus.shot_ready, 0);
        check("done armed", armed, 0);
        seen = 0;
        bus.shot_valid = 1'b1;
        bus.shot_addr  = 8'h00;
        repeat (5) begin
            @(negedge clk);
            if (bus.reply_valid) seen = 1;
        end
        bus.shot_valid = 1'b0;
        check("done no reply", seen, 0);

        // Setup corners.
        do_clear();
        check("clr defeated", defeated, 0);
        check("clr ship_cells", ship_cells, 0);
        place(8'h22, 1);
        check("place once", ship_cells, 1);
        place(8'h22, 1);
        check("place twice", ship_cells, 1);
        place(8'h22, 0);
        check("remove", ship_cells, 0);
        place(8'hA2, 1);
        check("place invalid", ship_cells, 0);
        do_arm();
        check("arm empty armed", armed, 0);
        check("arm empty ready", bus.shot_ready, 0);
        place(8'h22, 1);
        @(negedge clk);
        arm = 1'b1;
        place_we = 1'b1;
        place_addr = 8'h33;
        place_ship = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        place_we = 1'b0;
        check("arm+we ready", bus.shot_ready, 1);
        check("arm+we ship_cells", ship_cells, 1);
        check("arm+we cells_left", cells_left, 1);
        place(8'h44, 1);
        check("we in ready", ship_cells, 1);
        shoot("dropped33", 8'h33, 0, 2'b01, 1);
        shoot("ignored44", 8'h44, 0, 2'b01, 1);

        // Clear during REPLY.
        accept("clr_reply", 8'h22, ok);
        @(negedge clk);
        check("clr_reply rv", bus.reply_valid, 1);
        check("clr_reply code", bus.reply_code, 3);
        do_clear();
        check("clr_reply rv0", bus.reply_valid, 0);
        check("clr_reply armed", armed, 0);
        check("clr_reply ship", ship_cells, 0);
        check("clr_reply left", cells_left, 0);
        check("clr_reply ready", bus.shot_ready, 0);

        // Reset during CHECK.
        place(8'h01, 1);
        do_arm();
        accept("rst_chk", 8'h01, ok);
        rst_n = 1'b0;
        #1;
        check("rst_chk shot_ready", bus.shot_ready, 0);
        check("rst_chk reply_valid", bus.reply_valid, 0);
        check("rst_chk reply_code", bus.reply_code, 0);
        check("rst_chk ship_cells", ship_cells, 0);
        check("rst_chk cells_left", cells_left, 0);
        check("rst_chk armed", armed, 0);
        check("rst_chk defeated", defeated, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst rv", bus.reply_valid, 0);
        place(8'h01, 1);
        do_arm();
        shoot("post_rst", 8'h01, 0, 2'b11, 0);
        check("post_rst defeated", defeated, 1);

        // Random games against the model.
        for (int g = 0; g < 6; g++) begin
            do_clear();
            m_clear();
            for (int k = 0; k < int'($urandom_range(5, 25)); k++) begin
                r = 4'($urandom_range(0, 11));
                c = 4'($urandom_range(0, 11));
                a = {r, c};
                ok = ($urandom % 4) != 0;
                place(a, ok);
                m_place(a, ok);
                check($sformatf("g%0d place", g), ship_cells,
                      m_ship_count());
            end
            if (m_ship_count() == 0) begin
                place(8'h55, 1);
                m_place(8'h55, 1);
            end
            do_arm();
            check($sformatf("g%0d armed left", g), cells_left,
                  m_ship_count());
            ships.delete();
            for (int i = 0; i < 100; i++) begin
                if (m_ship[i]) ships.push_back({4'(i / 10), 4'(i % 10)});
            end
            for (int k = 0; k < 80; k++) begin
                if ($urandom % 2) begin
                    a = ships[$urandom_range(0, ships.size() - 1)];
                end else begin
                    r = 4'($urandom_range(0, 10));
                    c = 4'($urandom_range(0, 10));
                    a = {r, c};
                end
                ec = m_shot(a);
                shoot($sformatf("g%0d s%0d", g, k), a,
                      int'($urandom_range(0, 2)), ec, m_left());
                if (ec == 2'b11) break;
            end
            check($sformatf("g%0d defeated", g), defeated,
                  m_left() == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
